// File: rtl/tor_link_delay_pkg.sv
// Shared types for the emulated ToR link delay line.
// NetworkPacketInternal mirrors the NIC-side packet layout.
package tor_link_delay_pkg;

    localparam int unsigned TOR_TS_BITS     = 16;
    localparam int unsigned TOR_MIN_LATENCY = 2;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } NetworkPacketInternal;

    typedef struct packed {
        logic [TOR_TS_BITS-1:0] stamp;
        NetworkPacketInternal   pkt;
    } t_tor_delay_entry;

endpackage

// File: rtl/tor_link_delay_if.sv
// Packet stream bundle between a sending NIC, the delay line and the receiving NIC.
// master drives packets in and observes delivery; slave is the delay line.
interface tor_link_delay_if;
    import tor_link_delay_pkg::*;

    NetworkPacketInternal in_data;
    logic                 in_valid;
    NetworkPacketInternal out_data;
    logic                 out_valid;

    modport master (
        output in_data,
        output in_valid,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/tor_link_delay_fifo.sv
// Circular buffer of time-stamped packets with combinational head read.
// Push into a full buffer is only taken when a pop happens in the same cycle.
module tor_link_delay_fifo
    import tor_link_delay_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  t_tor_delay_entry      push_entry,
    input  logic                  pop,
    output t_tor_delay_entry      head,
    output logic [DEPTH_LOG2:0]   occupancy,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    t_tor_delay_entry        mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic                    push_ok;
    logic                    pop_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign head      = mem[rd_ptr_q];
    assign occupancy = count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/tor_link_delay.sv
// One direction of the emulated ToR network: delivers each packet a programmable
// number of cycles after it was sent, dropping and counting packets on overflow.
module tor_link_delay
    import tor_link_delay_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned LAT_BITS   = 8,
    parameter int unsigned TS_BITS    = TOR_TS_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [LAT_BITS-1:0]  latency_cfg,
    tor_link_delay_if.slave      link,
    output logic [DEPTH_LOG2:0]  occupancy,
    output logic [31:0]          fwd_cnt,
    output logic [31:0]          drop_cnt
);

    logic [TS_BITS-1:0]   ts_q;
    logic [LAT_BITS-1:0]  lat_eff;
    logic [TS_BITS-1:0]   lat_thresh;
    logic [TS_BITS-1:0]   head_age;
    t_tor_delay_entry     push_entry;
    t_tor_delay_entry     head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    NetworkPacketInternal out_data_q;
    logic                 out_valid_q;
    logic [31:0]          fwd_cnt_q;
    logic [31:0]          drop_cnt_q;

    always_comb begin
        lat_eff = latency_cfg;
        if (latency_cfg < LAT_BITS'(TOR_MIN_LATENCY)) lat_eff = LAT_BITS'(TOR_MIN_LATENCY);
    end

    // Modular age is exact: an entry never ages beyond L, which fits in TS_BITS.
    assign lat_thresh = TS_BITS'(lat_eff) - TS_BITS'(1);
    assign head_age   = ts_q - TS_BITS'(head.stamp);
    assign pop        = !fifo_empty && (head_age >= lat_thresh);
    assign push       = link.in_valid && (!fifo_full || pop);
    assign drop       = link.in_valid && !push;

    always_comb begin
        push_entry       = '0;
        push_entry.stamp = TOR_TS_BITS'(ts_q);
        push_entry.pkt   = link.in_data;
    end

    tor_link_delay_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .occupancy  (occupancy),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            fwd_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            ts_q        <= ts_q + 1'b1;
            out_valid_q <= pop;
            if (pop) out_data_q <= head.pkt;
            if (pop && (fwd_cnt_q != '1))   fwd_cnt_q  <= fwd_cnt_q + 32'd1;
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign link.out_data  = out_data_q;
    assign link.out_valid = out_valid_q;
    assign fwd_cnt        = fwd_cnt_q;
    assign drop_cnt       = drop_cnt_q;

endmodule
